// File: rtl/axi_wr_arb_pkg.sv
// Shared encodings for the two-master AXI write-burst arbiter.
package axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic [1:0] BRESP_OKAY     = 2'b00;
    localparam logic [1:0] BRESP_SLVERR   = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_write_burst_arbiter_rr_arb2.sv
// Two-requester round-robin pick; last_grant is the index of the previous owner.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_write_burst_arbiter.sv
// Shares one AXI4 write-burst slave between two masters, one whole transaction at a time,
// round-robin, and flags bursts whose wlast disagrees with the awlen beat count.
module axi_write_burst_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [LEN_WIDTH-1:0]    s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,

    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [LEN_WIDTH-1:0]    s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,

    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [LEN_WIDTH-1:0]    m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,

    output logic [1:0]              grant,
    output logic                    len_err
);

    arb_state_t           state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 len_err_q, len_err_d;
    logic [1:0]           arb_gnt;
    logic                 sel;
    logic                 final_beat;

    rr_arb2 u_rr_arb2 (
        .req        ({s1_awvalid, s0_awvalid}),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    assign sel        = grant_q[1];
    assign final_beat = (beat_cnt_q == len_q);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            len_err_q    <= len_err_d;
        end
    end

    // The burst always ends on the awlen count; a disagreeing wlast is only reported.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        len_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_awvalid || s1_awvalid) begin
                    grant_d = arb_gnt;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_awvalid && m_awready) begin
                    len_d      = m_awlen;
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_wvalid && m_wready) begin
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    len_err_d  = (m_wlast != final_beat);
                    if (final_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_bvalid && m_bready) begin
                    last_grant_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_awaddr  = sel ? s1_awaddr  : s0_awaddr;
        m_awlen   = sel ? s1_awlen   : s0_awlen;
        m_awsize  = sel ? s1_awsize  : s0_awsize;
        m_awburst = sel ? s1_awburst : s0_awburst;
        m_wdata   = sel ? s1_wdata   : s0_wdata;
        m_wstrb   = sel ? s1_wstrb   : s0_wstrb;
        m_wlast   = sel ? s1_wlast   : s0_wlast;
        m_awvalid = (state_q == ST_ADDR) && (sel ? s1_awvalid : s0_awvalid);
        m_wvalid  = (state_q == ST_DATA) && (sel ? s1_wvalid  : s0_wvalid);
        m_bready  = (state_q == ST_RESP) && (sel ? s1_bready  : s0_bready);

        s0_awready = (state_q == ST_ADDR) && grant_q[0] && m_awready;
        s1_awready = (state_q == ST_ADDR) && grant_q[1] && m_awready;
        s0_wready  = (state_q == ST_DATA) && grant_q[0] && m_wready;
        s1_wready  = (state_q == ST_DATA) && grant_q[1] && m_wready;
        s0_bvalid  = (state_q == ST_RESP) && grant_q[0] && m_bvalid;
        s1_bvalid  = (state_q == ST_RESP) && grant_q[1] && m_bvalid;
        s0_bresp   = ((state_q == ST_RESP) && grant_q[0]) ? m_bresp : BRESP_OKAY;
        s1_bresp   = ((state_q == ST_RESP) && grant_q[1]) ? m_bresp : BRESP_OKAY;

        grant   = grant_q;
        len_err = len_err_q;
    end

endmodule
